detection_window_scanner: RTL and testbench
===========================================

DETECTION_WINDOW_SCANNER -- requirements
Module: detection_window_scanner

Interface
REQ-001 Parameters SHALL be COORD_WIDTH=16 (coordinate width), FRAME_WIDTH=640 and FRAME_HEIGHT=480 (pixels), WIN_SIZE=64 (square window side), STRIDE=16 (step in x and y), and MAX_OUTSTANDING=8 (windows in flight, power of 2).
REQ-002 The block SHALL use one clock, pclk; reset_n_pclk SHALL be asynchronous and active-low.
REQ-003 pclk  in  1  pixel/classifier clock.
REQ-004 reset_n_pclk  in  1  asynchronous active-low reset.
REQ-005 frame_start_pclk  in  1  single-cycle pulse that starts a frame scan.
REQ-006 win_x_pclk, win_y_pclk  out  COORD_WIDTH each  top-left corner of the window offered to the classifier.
REQ-007 win_valid_pclk  out  1 / win_ready_pclk  in  1  window-offer handshake; a transfer occurs when both are high.
REQ-008 result_valid_pclk  in  1 / result_positive_pclk  in  1  one in-order classifier verdict per accepted window.
REQ-009 bbox_x_start_pclk, bbox_y_start_pclk, bbox_x_end_pclk, bbox_y_end_pclk  out  COORD_WIDTH each  detected box.
REQ-010 bbox_valid_pclk  out  1  single-cycle pulse qualifying the bbox outputs.
REQ-011 classification_done_pclk  out  1  single-cycle end-of-frame pulse.
REQ-012 busy_pclk  out  1  high from scan start until done is issued.
REQ-013 error_pclk  out  1  sticky protocol-error flag.

Function
REQ-014 States SHALL be IDLE, SCAN, DRAIN and DONE.
REQ-015 IDLE SHALL go to SCAN on frame_start_pclk, zeroing the x and y counters.
REQ-016 Window order SHALL be raster: x = 0, STRIDE, ... while x+WIN_SIZE <= FRAME_WIDTH; then y += STRIDE while y+WIN_SIZE <= FRAME_HEIGHT.
REQ-017 In SCAN, win_valid_pclk SHALL be high unless the coordinate FIFO holds MAX_OUTSTANDING entries.
REQ-018 win_x/win_y SHALL stay stable while win_valid_pclk is high and win_ready_pclk is low.
REQ-019 Each accepted window SHALL push {x,y} into the coordinate FIFO and advance the counters in the same cycle.
REQ-020 Acceptance of the last window SHALL move the FSM from SCAN to DRAIN.
REQ-021 Each result_valid_pclk SHALL pop one FIFO entry.
REQ-022 A positive result SHALL pulse bbox_valid_pclk exactly one cycle later, with x_start=x, y_start=y, x_end=x+WIN_SIZE-1, y_end=y+WIN_SIZE-1.
REQ-023 A negative result SHALL produce no output.
REQ-024 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged.
REQ-025 In DRAIN, the FIFO becoming empty after the final pop SHALL move the FSM to DONE.
REQ-026 DONE SHALL pulse classification_done_pclk for one cycle, at least one cycle after the last bbox_valid_pclk, then return to IDLE.
REQ-027 busy_pclk SHALL be low in IDLE.
REQ-028 frame_start_pclk outside IDLE SHALL be ignored.
REQ-029 result_valid_pclk while the FIFO is empty SHALL set error_pclk and be otherwise ignored.
REQ-030 error_pclk SHALL clear only on reset or on frame_start_pclk in IDLE.
REQ-031 All coordinate arithmetic SHALL be unsigned COORD_WIDTH with no wrap for legal parameters.
REQ-032 Elaboration SHALL fail if WIN_SIZE exceeds FRAME_WIDTH or FRAME_HEIGHT, or if STRIDE is 0.

Reset
REQ-033 On reset assertion all outputs SHALL go to 0, the FSM to IDLE, and the FIFO to empty, regardless of the scan in progress.
REQ-034 Reset deassertion SHALL be synchronized to pclk before the FSM leaves IDLE.

Configuration
REQ-035 With DETECTION_SCANNER_COUNT_EN defined, the block SHALL add output positive_cnt_pclk (COORD_WIDTH), which counts bbox_valid pulses, is reset on scan start, and holds its value after DONE.
REQ-036 Without DETECTION_SCANNER_COUNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-037 The state enum and a bbox struct typedef SHALL live in the shared package detection_pkg.
REQ-038 The coordinate FIFO SHALL be the sub-module detection_coord_fifo: synchronous, parameterized depth, with full and empty outputs.

Verification
REQ-039 Scenario: 64x48 frame, WIN_SIZE=32, STRIDE=16, ready tied high, all results positive -> 6 windows, boxes (0,0,31,31) through (32,16,63,47), then one classification_done_pclk.
REQ-040 Scenario: same frame, results pattern N,P,N,N,N,P -> exactly 2 bbox pulses, at (16,0) and (32,16), then classification_done_pclk.
REQ-041 Scenario: MAX_OUTSTANDING=2, results withheld -> win_valid_pclk drops after 2 transfers and resumes one cycle after the first result.
REQ-042 Scenario: win_ready_pclk toggling 1/0 every cycle -> coordinates stay stable while stalled, no window is skipped or duplicated.
REQ-043 Scenario: result_valid_pclk in IDLE -> error_pclk=1 and held; frame_start_pclk clears it.
REQ-044 Scenario: reset asserted mid-DRAIN -> busy_pclk=0 and all outputs 0 immediately; a new frame completes normally.

Source files
------------

// File: rtl/detection_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : detection_pkg                                                 |
// | Desc     : Shared scanner state encoding, bbox record and box helper.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package detection_pkg;

  localparam int BBOX_COORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  typedef logic [BBOX_COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x_start;
    coord_t y_start;
    coord_t x_end;
    coord_t y_end;
  } bbox_t;

  function automatic bbox_t bbox_from_corner(input coord_t x, input coord_t y,
                                             input coord_t side_m1);
    bbox_t b;
    b.x_start = x;
    b.y_start = y;
    b.x_end   = x + side_m1;
    b.y_end   = y + side_m1;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/detection_coord_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : detection_coord_fifo                                          |
// | Desc     : Synchronous FIFO holding window corners awaiting a verdict.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module detection_coord_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int            c_AW    = $clog2(DEPTH);
  localparam logic [c_AW:0] c_DEPTH = (c_AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & ~o_empty;
  assign o_full     = (r_count == c_DEPTH);
  assign o_empty    = (r_count == '0);
  assign o_pop_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Simultaneous push and pop leaves the occupancy untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_AW+1)'(1);
        2'b01:   r_count <= r_count - (c_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/detection_window_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : detection_window_scanner                                      |
// | Desc     : Raster window scanner pairing classifier verdicts with boxes. |
// |            DETECTION_SCANNER_COUNT_EN adds positive_cnt_pclk.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module detection_window_scanner
  import detection_pkg::*;
#(
  parameter int COORD_WIDTH     = 16,
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int WIN_SIZE        = 64,
  parameter int STRIDE          = 16,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   pclk,
  input  logic                   reset_n_pclk,
  input  logic                   frame_start_pclk,
  output logic [COORD_WIDTH-1:0] win_x_pclk,
  output logic [COORD_WIDTH-1:0] win_y_pclk,
  output logic                   win_valid_pclk,
  input  logic                   win_ready_pclk,
  input  logic                   result_valid_pclk,
  input  logic                   result_positive_pclk,
  output logic [COORD_WIDTH-1:0] bbox_x_start_pclk,
  output logic [COORD_WIDTH-1:0] bbox_y_start_pclk,
  output logic [COORD_WIDTH-1:0] bbox_x_end_pclk,
  output logic [COORD_WIDTH-1:0] bbox_y_end_pclk,
  output logic                   bbox_valid_pclk,
  output logic                   classification_done_pclk,
  output logic                   busy_pclk,
  output logic                   error_pclk
`ifdef DETECTION_SCANNER_COUNT_EN
  ,
  output logic [COORD_WIDTH-1:0] positive_cnt_pclk
`endif
);

  localparam int                     c_PAIR_W  = 2 * COORD_WIDTH;
  localparam logic [COORD_WIDTH-1:0] c_STRIDE  = COORD_WIDTH'(STRIDE);
  localparam logic [COORD_WIDTH-1:0] c_SIDE_M1 = COORD_WIDTH'(WIN_SIZE - 1);
  localparam logic [COORD_WIDTH-1:0] c_X_LAST  =
    COORD_WIDTH'((STRIDE > 0) ? ((FRAME_WIDTH - WIN_SIZE) / STRIDE) * STRIDE : 0);
  localparam logic [COORD_WIDTH-1:0] c_Y_LAST  =
    COORD_WIDTH'((STRIDE > 0) ? ((FRAME_HEIGHT - WIN_SIZE) / STRIDE) * STRIDE : 0);

  if (WIN_SIZE > FRAME_WIDTH || WIN_SIZE > FRAME_HEIGHT || STRIDE == 0 ||
      COORD_WIDTH != BBOX_COORD_W || MAX_OUTSTANDING < 2 ||
      (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_param_check
    $error("detection_window_scanner: illegal parameter set");
  end

  scan_state_t            r_state;
  logic [1:0]             r_rst_sync;
  logic [COORD_WIDTH-1:0] r_x;
  logic [COORD_WIDTH-1:0] r_y;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;
  logic                   r_bbox_valid;
  bbox_t                  r_bbox;

  logic                   w_start;
  logic                   w_accept;
  logic                   w_pop;
  logic                   w_orphan;
  logic                   w_last_window;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [c_PAIR_W-1:0]    w_head;
  logic [COORD_WIDTH-1:0] w_head_x;
  logic [COORD_WIDTH-1:0] w_head_y;

  // Deassertion is retimed so the FSM only starts once reset is cleanly released.
  always_ff @(posedge pclk or negedge reset_n_pclk) begin
    if (!reset_n_pclk) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_start       = (r_state == ST_IDLE) & frame_start_pclk & r_rst_sync[1];
  assign w_accept      = win_valid_pclk & win_ready_pclk;
  assign w_pop         = result_valid_pclk & ~w_fifo_empty;
  assign w_orphan      = result_valid_pclk & w_fifo_empty;
  assign w_last_window = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
  assign w_head_x      = w_head[c_PAIR_W-1:COORD_WIDTH];
  assign w_head_y      = w_head[COORD_WIDTH-1:0];

  detection_coord_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (c_PAIR_W)
  ) u_coord_fifo (
    .clk         (pclk),
    .rst_n       (reset_n_pclk),
    .i_push      (w_accept),
    .i_push_data ({r_x, r_y}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  always_ff @(posedge pclk or negedge reset_n_pclk) begin
    if (!reset_n_pclk) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_bbox_valid <= 1'b0;
      r_bbox       <= '0;
    end else begin
      r_done       <= 1'b0;
      r_bbox_valid <= w_pop & result_positive_pclk;
      if (w_pop && result_positive_pclk) begin
        r_bbox <= bbox_from_corner(w_head_x, w_head_y, c_SIDE_M1);
      end
      if (w_start) begin
        r_error <= 1'b0;
      end
      if (w_orphan) begin
        r_error <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_SCAN;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (w_accept) begin
            if (w_last_window) begin
              r_state <= ST_DRAIN;
            end else if (r_x == c_X_LAST) begin
              r_x <= '0;
              r_y <= r_y + c_STRIDE;
            end else begin
              r_x <= r_x + c_STRIDE;
            end
          end
        end
        ST_DRAIN: begin
          // The final bbox has already been issued when the FIFO reads empty here.
          if (w_fifo_empty) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign win_x_pclk               = r_x;
  assign win_y_pclk               = r_y;
  assign win_valid_pclk           = (r_state == ST_SCAN) & ~w_fifo_full;
  assign bbox_x_start_pclk        = r_bbox.x_start;
  assign bbox_y_start_pclk        = r_bbox.y_start;
  assign bbox_x_end_pclk          = r_bbox.x_end;
  assign bbox_y_end_pclk          = r_bbox.y_end;
  assign bbox_valid_pclk          = r_bbox_valid;
  assign classification_done_pclk = r_done;
  assign busy_pclk                = r_busy;
  assign error_pclk               = r_error;

`ifdef DETECTION_SCANNER_COUNT_EN
  logic [COORD_WIDTH-1:0] r_pos_cnt;

  always_ff @(posedge pclk or negedge reset_n_pclk) begin
    if (!reset_n_pclk) begin
      r_pos_cnt <= '0;
    end else if (w_start) begin
      r_pos_cnt <= '0;
    end else if (r_bbox_valid) begin
      r_pos_cnt <= r_pos_cnt + COORD_WIDTH'(1);
    end
  end

  assign positive_cnt_pclk = r_pos_cnt;
`else
  // Positive-count port is absent in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_detection_window_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_detection_window_scanner                                   |
// | Desc     : Scoreboard bench for detection_window_scanner on a 64x48 frame|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_detection_window_scanner;

  localparam int FW = 64;
  localparam int FH = 48;
  localparam int WS = 32;
  localparam int ST = 16;
  localparam int MO = 2;
  localparam int NWIN = 6;

  typedef struct {
    logic [15:0] xs;
    logic [15:0] ys;
    logic [15:0] xe;
    logic [15:0] ye;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } win_t;

  logic        pclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        win_ready = 1'b1;
  logic        result_valid = 1'b0;
  logic        result_positive = 1'b0;
  logic [15:0] win_x, win_y;
  logic        win_valid;
  logic [15:0] bb_xs, bb_ys, bb_xe, bb_ye;
  logic        bbox_valid, done, busy, error;
`ifdef DETECTION_SCANNER_COUNT_EN
  logic [15:0] pos_cnt;
`endif

  exp_t exp_q[$];
  win_t acc_q[$];
  int   n_err = 0;
  int   n_chk = 0;
  int   cyc = 0;
  int   m_x = 0;
  int   m_y = 0;
  int   win_cnt = 0;
  int   frame_bbox = 0;
  int   done_cnt = 0;
  bit   prev_stall = 1'b0;

  detection_window_scanner #(
    .COORD_WIDTH     (16),
    .FRAME_WIDTH     (FW),
    .FRAME_HEIGHT    (FH),
    .WIN_SIZE        (WS),
    .STRIDE          (ST),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .pclk                     (pclk),
    .reset_n_pclk             (reset_n),
    .frame_start_pclk         (frame_start),
    .win_x_pclk               (win_x),
    .win_y_pclk               (win_y),
    .win_valid_pclk           (win_valid),
    .win_ready_pclk           (win_ready),
    .result_valid_pclk        (result_valid),
    .result_positive_pclk     (result_positive),
    .bbox_x_start_pclk        (bb_xs),
    .bbox_y_start_pclk        (bb_ys),
    .bbox_x_end_pclk          (bb_xe),
    .bbox_y_end_pclk          (bb_ye),
    .bbox_valid_pclk          (bbox_valid),
    .classification_done_pclk (done),
    .busy_pclk                (busy),
    .error_pclk               (error)
`ifdef DETECTION_SCANNER_COUNT_EN
    ,
    .positive_cnt_pclk        (pos_cnt)
`endif
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Window monitor: offered coordinates must follow the raster model.
  always @(negedge pclk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_keep_valid", win_valid, 1);
      if (win_valid) begin
        chk("win_x", win_x, m_x);
        chk("win_y", win_y, m_y);
      end
      if (win_valid && win_ready) begin
        win_t w;
        w.x = 16'(m_x);
        w.y = 16'(m_y);
        acc_q.push_back(w);
        win_cnt++;
        chk("busy_scan", busy, 1);
        if (m_x + ST + WS > FW) begin
          m_x = 0;
          m_y = m_y + ST;
        end else begin
          m_x = m_x + ST;
        end
      end
      prev_stall = win_valid && !win_ready;
    end
  end

  // Bbox / done monitor.
  always @(negedge pclk) begin
    if (reset_n && bbox_valid) begin
      frame_bbox++;
      if (exp_q.size() == 0) begin
        chk("bbox_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bbox_xs", bb_xs, e.xs);
        chk("bbox_ys", bb_ys, e.ys);
        chk("bbox_xe", bb_xe, e.xe);
        chk("bbox_ye", bb_ye, e.ye);
        chk("bbox_lat", cyc, e.cyc);
      end
    end
    if (reset_n && done) begin
      done_cnt++;
      chk("done_gap", bbox_valid, 0);
      chk("done_sb_empty", exp_q.size(), 0);
    end
  end

  task automatic run_frame(input logic [5:0] pos_mask, input bit toggle_rdy,
                           input int hold, input int res_limit);
    int cycles = 0;
    int res_idx = 0;
    bit resume = 1'b0;
    bit done_seen = 1'b0;
    int done0 = done_cnt;
    m_x = 0;
    m_y = 0;
    win_cnt = 0;
    frame_bbox = 0;
    @(posedge pclk); #1 frame_start = 1'b1;
    @(posedge pclk); #1 frame_start = 1'b0;
    chk("busy_start", busy, 1);
    chk("err_clear", error, 0);
    while (cycles < 300) begin
      if (resume) begin
        chk("resume_valid", win_valid, 1);
        resume = 1'b0;
      end
      if (done_cnt != done0) begin
        done_seen = 1'b1;
        break;
      end
      if (res_limit < NWIN && res_idx == res_limit && win_cnt == NWIN) break;
      win_ready = toggle_rdy ? ~win_ready : 1'b1;
      result_valid = 1'b0;
      result_positive = 1'b0;
      if (cycles >= hold && res_idx < res_limit && acc_q.size() > 0) begin
        win_t w;
        if (hold > 0 && res_idx == 0) begin
          chk("full_stall", win_valid, 0);
          chk("full_count", win_cnt, MO);
          resume = 1'b1;
        end
        w = acc_q.pop_front();
        result_valid = 1'b1;
        result_positive = pos_mask[res_idx];
        if (pos_mask[res_idx]) begin
          exp_t e;
          e.xs = w.x;
          e.ys = w.y;
          e.xe = w.x + 16'(WS - 1);
          e.ye = w.y + 16'(WS - 1);
          e.cyc = cyc + 1;
          exp_q.push_back(e);
        end
        res_idx++;
      end
      @(posedge pclk); #1;
      cycles++;
    end
    result_valid = 1'b0;
    result_positive = 1'b0;
    win_ready = 1'b1;
    if (res_limit == NWIN) begin
      chk("frame_done", done_seen, 1);
      repeat (4) @(posedge pclk);
      #1;
      chk("done_once", done_cnt - done0, 1);
      chk("win_total", win_cnt, NWIN);
      chk("bbox_total", frame_bbox, $countones(pos_mask));
      chk("sb_empty", exp_q.size(), 0);
      chk("busy_idle", busy, 0);
      chk("err_clean", error, 0);
`ifdef DETECTION_SCANNER_COUNT_EN
      chk("pos_cnt", pos_cnt, $countones(pos_mask));
`endif
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge pclk);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bbox_valid", bbox_valid, 0);
    chk("rst_error", error, 0);
    chk("rst_win_x", win_x, 0);
    chk("rst_bbox_xe", bb_xe, 0);
    @(posedge pclk); #1 reset_n = 1'b1;
    repeat (3) @(posedge pclk);

    run_frame(6'b111111, 1'b0, 0, NWIN);   // all positive
    run_frame(6'b100010, 1'b0, 0, NWIN);   // N,P,N,N,N,P
    run_frame(6'b010101, 1'b0, 8, NWIN);   // results withheld, FIFO fills
    run_frame(6'b111111, 1'b1, 0, NWIN);   // ready toggling

    // Orphan result in IDLE sets a sticky error.
    @(posedge pclk); #1 result_valid = 1'b1;
    @(posedge pclk); #1 result_valid = 1'b0;
    chk("err_set", error, 1);
    repeat (3) @(posedge pclk);
    #1 chk("err_hold", error, 1);
    run_frame(6'b001100, 1'b0, 0, NWIN);

    // Reset in the middle of DRAIN.
    run_frame(6'b111111, 1'b0, 0, 4);
    chk("busy_drain", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_win_valid", win_valid, 0);
    chk("mid_rst_bbox_valid", bbox_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_win_x", win_x, 0);
    chk("mid_rst_bbox_xs", bb_xs, 0);
    exp_q.delete();
    acc_q.delete();
    repeat (2) @(posedge pclk);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge pclk);
    run_frame(6'b110011, 1'b0, 0, NWIN);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
